usb_bit_unstuffer: RTL and testbench

//  Receive-side counterpart of the USB TX bit stuffer. Sits between the NRZI decoder and the RX shift register.
//  - After six consecutive 1s, the next valid bit must be a stuffed 0. That bit is removed from the stream.
//  - A 1 in that position is a bit-stuff error: it is flagged and the rest of the packet is suppressed.

---
 rtl/usb_bit_unstuffer_if.sv | 56 +++++
 rtl/usb_bit_unstuffer.sv | 161 ++++++++++++++++
 tb/tb_usb_bit_unstuffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/usb_bit_unstuffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : usb_bit_unstuffer_if
//  Brief    : Bit-stream bundle between the NRZI decoder, the bit unstuffer
//             and the RX shift register. The err_count member is present
//             only when USB_UNSTUFF_ERR_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface usb_bit_unstuffer_if #(
  parameter int ERR_CNT_W = 8
);
  logic in_bit;
  logic in_valid;
  logic pkt_clr;
  logic out_bit;
  logic out_valid;
  logic stuff_err;
  logic err_active;
`ifdef USB_UNSTUFF_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`else
  // Width is only meaningful when the error counter is built in.
  if (ERR_CNT_W > 0) begin : g_err_cnt_w_unused
  end
`endif

  // Upstream side: supplies decoded bits and packet boundaries.
  modport master (
    output in_bit,
    output in_valid,
    output pkt_clr,
    input  out_bit,
    input  out_valid,
    input  stuff_err,
`ifdef USB_UNSTUFF_ERR_CNT_EN
    input  err_count,
`endif
    input  err_active
  );

  // Unstuffer side: consumes decoded bits, produces the unstuffed stream.
  modport slave (
    input  in_bit,
    input  in_valid,
    input  pkt_clr,
    output out_bit,
    output out_valid,
    output stuff_err,
`ifdef USB_UNSTUFF_ERR_CNT_EN
    output err_count,
`endif
    output err_active
  );
endinterface
`default_nettype wire

// File: rtl/usb_bit_unstuffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : usb_bit_unstuffer
//  Brief    : USB receive bit unstuffer. Removes the stuffed 0 that follows
//             RUN_LEN consecutive 1s; a 1 in that slot is a bit-stuff error
//             which suppresses the rest of the packet until pkt_clr.
//             Optional feature macro: USB_UNSTUFF_ERR_CNT_EN adds a
//             saturating err_count output cleared only by nRST.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_bit_unstuffer #(
  parameter int RUN_LEN   = 6,
  parameter int ERR_CNT_W = 8
) (
  input  wire logic          clk,
  input  wire logic          nRST,
  usb_bit_unstuffer_if.slave bus
);

  localparam int              c_CNT_W     = $clog2(RUN_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_RUN    = c_CNT_W'(RUN_LEN);

  localparam logic [1:0]      c_ST_NORMAL = 2'd0;
  localparam logic [1:0]      c_ST_DROP   = 2'd1;
  localparam logic [1:0]      c_ST_ERROR  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_ones_cnt;
  logic [c_CNT_W-1:0] w_ones_nxt;
  logic [c_CNT_W-1:0] w_ones_inc;

  logic               r_out_bit;
  logic               r_out_valid;
  logic               r_stuff_err;
  logic               r_err_active;
  logic               w_out_bit_nxt;
  logic               w_out_valid_nxt;
  logic               w_stuff_err_nxt;
  logic               w_err_active_nxt;

  // A bit is consumed only when valid and not overridden by a packet boundary.
  logic               w_take;
  assign w_take     = bus.in_valid & ~bus.pkt_clr;
  assign w_ones_inc = r_ones_cnt + 1'b1;

  // State and run-length register; reset mid-packet restarts cleanly.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= c_ST_NORMAL;
      r_ones_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ones_cnt <= w_ones_nxt;
    end
  end

  // Next-state and run-count logic; idle cycles leave the run untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_ones_nxt  = r_ones_cnt;
    if (bus.pkt_clr) begin
      // Boundary abandons any pending drop or error without flagging.
      w_state_nxt = c_ST_NORMAL;
      w_ones_nxt  = '0;
    end else if (bus.in_valid) begin
      case (r_state)
        c_ST_NORMAL: begin
          if (bus.in_bit) begin
            if (w_ones_inc == c_RUN) begin
              w_state_nxt = c_ST_DROP;
              w_ones_nxt  = '0;
            end else begin
              w_ones_nxt  = w_ones_inc;
            end
          end else begin
            w_ones_nxt = '0;
          end
        end
        c_ST_DROP: begin
          w_ones_nxt  = '0;
          w_state_nxt = bus.in_bit ? c_ST_ERROR : c_ST_NORMAL;
        end
        c_ST_ERROR: begin
          w_state_nxt = c_ST_ERROR;
        end
        default: begin
          w_state_nxt = c_ST_NORMAL;
          w_ones_nxt  = '0;
        end
      endcase
    end
  end

  // Output decode: data strobes only in NORMAL, error pulse only from DROP,
  // so a data strobe and stuff_err can never coincide.
  always_comb begin
    w_out_valid_nxt  = 1'b0;
    w_out_bit_nxt    = r_out_bit;
    w_stuff_err_nxt  = 1'b0;
    if (w_take) begin
      case (r_state)
        c_ST_NORMAL: begin
          w_out_valid_nxt = 1'b1;
          w_out_bit_nxt   = bus.in_bit;
        end
        c_ST_DROP: begin
          w_stuff_err_nxt = bus.in_bit;
        end
        default: begin
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
    w_err_active_nxt = (w_state_nxt == c_ST_ERROR);
  end

  // Registered outputs; out_bit holds its last data value between strobes.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_err_active <= 1'b0;
    end else begin
      r_out_bit    <= w_out_bit_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_stuff_err  <= w_stuff_err_nxt;
      r_err_active <= w_err_active_nxt;
    end
  end

  assign bus.out_bit    = r_out_bit;
  assign bus.out_valid  = r_out_valid;
  assign bus.stuff_err  = r_stuff_err;
  assign bus.err_active = r_err_active;

`ifdef USB_UNSTUFF_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [ERR_CNT_W-1:0] r_err_count;

  // Saturating violation counter; survives packet boundaries.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_err_count <= '0;
    end else if (w_stuff_err_nxt && (r_err_count != c_ERR_MAX)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.err_count = r_err_count;
`else
  // Counter width is only meaningful when the error counter is built in.
  if (ERR_CNT_W > 0) begin : g_err_cnt_w_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_bit_unstuffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_usb_bit_unstuffer
//  Brief    : Directed self-checking bench for usb_bit_unstuffer. The error
//             counter steps run only when USB_UNSTUFF_ERR_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_bit_unstuffer;

  logic clk;
  logic nRST;
  int   n_cmp;
  int   n_fail;

  usb_bit_unstuffer_if #(.ERR_CNT_W(2)) bus ();

  usb_bit_unstuffer #(
    .RUN_LEN   (6),
    .ERR_CNT_W (2)
  ) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one input cycle, then check the registered outputs 1 ns after the edge.
  task automatic step(input logic v, input logic b, input logic c,
                      input logic e_ov, input logic e_ob,
                      input logic e_se, input logic e_ea, input string tag);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.pkt_clr  = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.pkt_clr  = 1'b0;
    chk({tag, ".out_valid"},  {7'd0, bus.out_valid},  {7'd0, e_ov});
    if (e_ov) chk({tag, ".out_bit"}, {7'd0, bus.out_bit}, {7'd0, e_ob});
    chk({tag, ".stuff_err"},  {7'd0, bus.stuff_err},  {7'd0, e_se});
    chk({tag, ".err_active"}, {7'd0, bus.err_active}, {7'd0, e_ea});
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    nRST         = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    bus.pkt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid",  {7'd0, bus.out_valid},  8'd0);
    chk("rst.out_bit",    {7'd0, bus.out_bit},    8'd0);
    chk("rst.stuff_err",  {7'd0, bus.stuff_err},  8'd0);
    chk("rst.err_active", {7'd0, bus.err_active}, 8'd0);
`ifdef USB_UNSTUFF_ERR_CNT_EN
    chk("rst.err_count", {6'd0, bus.err_count}, 8'd0);
`endif
    @(negedge clk);
    nRST = 1'b1;

    // 1: 0,1x6,0,1 -> 0,1x6 out, stuffed 0 dropped, trailing 1 passes
    step(1, 0, 0, 1, 0, 0, 0, "t1.b0");
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t1.one");
    step(1, 0, 0, 0, 0, 0, 0, "t1.stuffed");
    step(1, 1, 0, 1, 1, 0, 0, "t1.b8");

    // 2: seven 1s -> error, packet suppressed until pkt_clr
    step(0, 0, 1, 0, 0, 0, 0, "t2.clr0");
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t2.one");
    step(1, 1, 0, 0, 0, 1, 1, "t2.err");
    step(1, 0, 0, 0, 0, 0, 1, "t2.sup0");
    step(1, 1, 0, 0, 0, 0, 1, "t2.sup1");
    step(1, 0, 0, 0, 0, 0, 1, "t2.sup2");
    step(0, 0, 1, 0, 0, 0, 0, "t2.clr");
    step(1, 0, 0, 1, 0, 0, 0, "t2.after");

    // 3: run of 1s continues across an in_valid gap
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 0, 0, "t3.onea");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, "t3.gap");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 0, 0, "t3.oneb");
    step(1, 0, 0, 0, 0, 0, 0, "t3.stuffed");
    // stuffed 0 as last bit before boundary was dropped; boundary is clean
    step(0, 0, 1, 0, 0, 0, 0, "t3.clr");

    // 4: pkt_clr mid-run wins over a simultaneous valid bit
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 1, 0, 0, "t4.onea");
    step(1, 1, 1, 0, 0, 0, 0, "t4.clrbit");
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t4.oneb");
    step(1, 0, 0, 0, 0, 0, 0, "t4.stuffed");

    // 5: asynchronous reset mid-packet
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 1, 0, 0, "t5.onea");
    #2;
    nRST = 1'b0;
    #1;
    chk("t5.async.out_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("t5.async.out_bit",   {7'd0, bus.out_bit},   8'd0);
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t5.oneb");
    step(1, 0, 0, 0, 0, 0, 0, "t5.stuffed");

    // 7: pending DROP abandoned by pkt_clr, no error, next 1 passes
    for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t7.one");
    step(0, 0, 1, 0, 0, 0, 0, "t7.clr");
    step(1, 1, 0, 1, 1, 0, 0, "t7.after");

`ifdef USB_UNSTUFF_ERR_CNT_EN
    // 6: saturating error counter (ERR_CNT_W=2), kept across pkt_clr
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 0, 0, "t6.clr");
      for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 1, 0, 0, "t6.one");
      step(1, 1, 0, 0, 0, 1, 1, "t6.err");
      chk("t6.err_count", {6'd0, bus.err_count}, (k >= 2) ? 8'd3 : 8'(k + 1));
    end
    step(0, 0, 1, 0, 0, 0, 0, "t6.clrkeep");
    chk("t6.err_count_kept", {6'd0, bus.err_count}, 8'd3);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6.err_count_rst", {6'd0, bus.err_count}, 8'd0);
    @(negedge clk);
    nRST = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
